// File: rtl/ins_cache_r32i_if.sv
// Fetch-side and refill-side signals of the RV32I instruction cache.
// The slave modport is the cache; the master modport is the PC plus backing memory.
interface ins_cache_r32i_if #(
    parameter int dataW = 32
);
    logic [dataW-1:0] ProgAddr;
    logic             Flush;
    logic [dataW-1:0] Instruction;
    logic             InsCacheStall;
    logic             Misaligned;
    logic             MemReq;
    logic [dataW-1:0] MemAddr;
    logic             MemAck;
    logic [dataW-1:0] MemData;

    modport slave (
        input  ProgAddr, Flush, MemAck, MemData,
        output Instruction, InsCacheStall, Misaligned, MemReq, MemAddr
    );

    modport master (
        output ProgAddr, Flush, MemAck, MemData,
        input  Instruction, InsCacheStall, Misaligned, MemReq, MemAddr
    );
endinterface

// File: rtl/ins_cache_r32i.sv
// Direct-mapped read-only instruction cache with single-word refill beats
// and FENCE.I flush; stalls the PC while a line is fetched.
module ins_cache_r32i #(
    parameter int dataW     = 32,
    parameter int lineCount = 16,
    parameter int lineWords = 4
) (
    input  logic              clock,
    input  logic              nreset,
    ins_cache_r32i_if.slave   bus
);
    localparam int WORD_BITS = $clog2(lineWords);
    localparam int IDX_BITS  = $clog2(lineCount);
    localparam int TAG_BITS  = dataW - 2 - WORD_BITS - IDX_BITS;
    localparam logic [dataW-1:0] NOP = dataW'(32'h0000_0013);

    typedef enum logic {IDLE, REFILL} state_t;

    state_t state, state_next;

    logic [lineCount-1:0] valid;
    logic [TAG_BITS-1:0]  tags [lineCount];
    logic [dataW-1:0]     data [lineCount][lineWords];

    logic [TAG_BITS-1:0]  refill_tag;
    logic [IDX_BITS-1:0]  refill_idx;
    logic [WORD_BITS-1:0] beat;
    logic                 discard;

    logic [TAG_BITS-1:0]  tag;
    logic [IDX_BITS-1:0]  idx;
    logic [WORD_BITS-1:0] word;
    logic                 hit;
    logic                 beat_ack;
    logic                 last_beat;

    assign tag       = bus.ProgAddr[dataW-1 -: TAG_BITS];
    assign idx       = bus.ProgAddr[2+WORD_BITS +: IDX_BITS];
    assign word      = bus.ProgAddr[2 +: WORD_BITS];
    assign hit       = (state == IDLE) && valid[idx] && (tags[idx] == tag) && !bus.Flush;
    assign beat_ack  = (state == REFILL) && bus.MemAck;
    assign last_beat = &beat;

    assign bus.Misaligned = bus.ProgAddr[1];

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!bus.Flush && !hit) state_next = REFILL;
            REFILL:  if (beat_ack && last_beat) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.Instruction   = NOP;
        bus.InsCacheStall = 1'b1;
        bus.MemReq        = 1'b0;
        bus.MemAddr       = '0;
        if (hit) begin
            bus.Instruction   = data[idx][word];
            bus.InsCacheStall = 1'b0;
        end
        if (state == REFILL) begin
            bus.MemReq  = 1'b1;
            bus.MemAddr = {refill_tag, refill_idx, beat, 2'b00};
        end
    end

    // The victim line is invalidated at refill start so a discarded refill never
    // leaves stale data marked valid under the old tag.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            valid      <= '0;
            beat       <= '0;
            discard    <= 1'b0;
            refill_tag <= '0;
            refill_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.Flush) begin
                        valid <= '0;
                    end else if (!hit) begin
                        refill_tag  <= tag;
                        refill_idx  <= idx;
                        beat        <= '0;
                        valid[idx]  <= 1'b0;
                    end
                end
                REFILL: begin
                    if (bus.Flush) begin
                        valid   <= '0;
                        discard <= 1'b1;
                    end
                    if (bus.MemAck) begin
                        beat <= beat + 1'b1;
                        if (last_beat) begin
                            if (!discard && !bus.Flush) valid[refill_idx] <= 1'b1;
                            discard <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Tag and data arrays carry no reset; valid bits alone gate their use.
    always_ff @(posedge clock) begin
        if (beat_ack) begin
            data[refill_idx][beat] <= bus.MemData;
            if (last_beat) tags[refill_idx] <= refill_tag;
        end
    end
endmodule

// File: tb/tb_ins_cache_r32i.sv
// Scoreboard bench for ins_cache_r32i: directed fetch sequences push expected
// refill addresses and instructions; a negedge monitor pops and compares them.
module tb_ins_cache_r32i;
    logic clk = 1'b0;
    logic nreset;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] exp_addr  [$];
    logic [31:0] exp_instr [$];

    ins_cache_r32i_if #(.dataW(32)) bus ();

    ins_cache_r32i #(.dataW(32), .lineCount(16), .lineWords(4)) dut (
        .clock  (clk),
        .nreset (nreset),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Backing memory: word at byte address a holds 0xA0 + a/4.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h0000_00A0 + (a >> 2);
    endfunction

    assign bus.MemData = mem_word(bus.MemAddr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (nreset) begin
            if (bus.MemReq && bus.MemAck) begin
                if (exp_addr.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL unexpected_beat: got addr %h, expected none", bus.MemAddr);
                end else begin
                    check("mem_addr", bus.MemAddr, exp_addr.pop_front());
                end
            end
            if (!bus.InsCacheStall) begin
                if (exp_instr.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL unexpected_hit: got instr %h at %h, expected stall", bus.Instruction, bus.ProgAddr);
                end else begin
                    check("instruction", bus.Instruction, exp_instr.pop_front());
                end
                check("hit_memreq", {31'd0, bus.MemReq}, 32'd0);
            end
        end
    end

    // Present a missing address and ride out the refill(s); optional ack gap
    // before beat gap_beat and a one-cycle flush during beat flush_beat.
    task automatic miss_fetch(input logic [31:0] addr, input int refills, input int exp_stall,
                              input logic [31:0] exp_ins, input int gap_beat, input int gap_len,
                              input int flush_beat);
        logic [31:0] base;
        int cnt, beats, gap;
        bit flushed;
        step();
        bus.ProgAddr = addr;
        bus.Flush    = 1'b0;
        base = addr & ~32'h0000_000F;
        for (int r = 0; r < refills; r++)
            for (int b = 0; b < 4; b++) exp_addr.push_back(base + 32'(b * 4));
        exp_instr.push_back(exp_ins);
        cnt = 0; beats = 0; gap = gap_len; flushed = 1'b0;
        forever begin
            if (bus.MemReq && beats == gap_beat && gap > 0) begin
                bus.MemAck = 1'b0;
                gap--;
            end else begin
                bus.MemAck = 1'b1;
            end
            if (bus.MemReq && beats == flush_beat && !flushed) begin
                bus.Flush = 1'b1;
                flushed = 1'b1;
            end else begin
                bus.Flush = 1'b0;
            end
            #1;
            if (!bus.InsCacheStall || cnt >= 60) break;
            if (bus.MemReq && !bus.MemAck)
                check("hold_addr", bus.MemAddr, base + 32'(gap_beat) * 32'd4);
            if (bus.MemReq && bus.MemAck) beats++;
            cnt++;
            step();
        end
        bus.MemAck = 1'b1;
        bus.Flush  = 1'b0;
        check("stall_len", 32'(cnt), 32'(exp_stall));
    endtask

    task automatic fetch_hit(input logic [31:0] addr, input logic [31:0] exp_ins);
        step();
        bus.ProgAddr = addr;
        exp_instr.push_back(exp_ins);
        #1;
        check("hit_stall", {31'd0, bus.InsCacheStall}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time exceeded, expected completion");
        $fatal(1);
    end

    initial begin
        nreset       = 1'b0;
        bus.ProgAddr = 32'h0000_0002;
        bus.Flush    = 1'b1;
        bus.MemAck   = 1'b1;
        #1;
        check("rst_stall", {31'd0, bus.InsCacheStall}, 32'd1);
        check("rst_instr", bus.Instruction, 32'h0000_0013);
        check("rst_memreq", {31'd0, bus.MemReq}, 32'd0);
        check("rst_memaddr", bus.MemAddr, 32'd0);
        check("misaligned", {31'd0, bus.Misaligned}, 32'd1);
        step();
        step();
        nreset = 1'b1;

        // Cold miss then line hits
        miss_fetch(32'h0000_0000, 1, 5, 32'h0000_00A0, -1, 0, -1);
        fetch_hit(32'h0000_0004, 32'h0000_00A1);
        fetch_hit(32'h0000_0008, 32'h0000_00A2);
        fetch_hit(32'h0000_000C, 32'h0000_00A3);

        // Conflict eviction on index 0
        miss_fetch(32'h0000_0100, 1, 5, 32'h0000_00E0, -1, 0, -1);
        miss_fetch(32'h0000_0000, 1, 5, 32'h0000_00A0, -1, 0, -1);

        // Backpressure: three idle ack cycles before beat 2
        miss_fetch(32'h0000_0020, 1, 8, 32'h0000_00A8, 2, 3, -1);
        fetch_hit(32'h0000_0028, 32'h0000_00AA);

        // Flush during beat 1: line discarded and refetched, line 0 lost too
        miss_fetch(32'h0000_0040, 2, 10, 32'h0000_00B0, -1, 0, 1);
        miss_fetch(32'h0000_0000, 1, 5, 32'h0000_00A0, -1, 0, -1);

        // Reset during beat 2 of a refill
        step();
        bus.ProgAddr = 32'h0000_0060;
        exp_addr.push_back(32'h0000_0060);
        exp_addr.push_back(32'h0000_0064);
        repeat (3) step();
        check("pre_reset_addr", bus.MemAddr, 32'h0000_0068);
        nreset = 1'b0;
        #1;
        check("async_memreq", {31'd0, bus.MemReq}, 32'd0);
        check("async_memaddr", bus.MemAddr, 32'd0);
        check("async_stall", {31'd0, bus.InsCacheStall}, 32'd1);
        check("async_instr", bus.Instruction, 32'h0000_0013);
        step();
        nreset    = 1'b1;
        bus.Flush = 1'b1;
        miss_fetch(32'h0000_0000, 1, 5, 32'h0000_00A0, -1, 0, -1);

        // Flush in IDLE forces a stall and a following miss
        step();
        bus.Flush = 1'b1;
        #1;
        check("idle_flush_stall", {31'd0, bus.InsCacheStall}, 32'd1);
        miss_fetch(32'h0000_0000, 1, 5, 32'h0000_00A0, -1, 0, -1);

        // Misaligned address still looks up by word
        fetch_hit(32'h0000_0006, 32'h0000_00A1);
        check("misaligned_hit", {31'd0, bus.Misaligned}, 32'd1);

        step();
        bus.Flush = 1'b1;
        step();
        step();
        check("addr_queue_drained", 32'(exp_addr.size()), 32'd0);
        check("instr_queue_drained", 32'(exp_instr.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
